ps2_keyboard_rx: RTL

Host-side receiver for the board PS/2 keyboard port. The keyboard is the transmitter; this block samples PS2_CLK/PS2_DAT, deframes 11-bit frames and delivers validated scan-code bytes. It also decodes the space-bar make/break sequence into a single-cycle flap pulse and a held level. Both feed the game-input PIO alongside the push-button key.

---
 rtl/ps2_pkg.sv | 7 +
 rtl/ps2_clk_filter.sv | 38 +++
 rtl/ps2_keyboard_rx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding and scan-code constants for the PS/2 receiver
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE = 8'hE0;
   localparam logic [7:0] DEFAULT_FLAP_CODE = 8'h29;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronizes PS/2 pins, deglitches the clock and strobes its falling edge
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_dat,
   output logic fall_stb,
   output logic data_s
);
   localparam int CW = $clog2(FILTER_LEN + 1);
   logic [1:0] clk_sync, dat_sync;
   logic filt, filt_d;
   logic [CW-1:0] cnt;
   assign data_s = dat_sync[1];
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt <= 1'b1;
         filt_d <= 1'b1;
         cnt <= '0;
         fall_stb <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
         filt_d <= filt;
         fall_stb <= filt_d & ~filt;
         // any sample agreeing with the filtered level restarts the run count
         if (clk_sync[1] == filt) cnt <= '0;
         else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt <= clk_sync[1];
            cnt <= '0;
         end else cnt <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: deframes PS/2 keyboard bytes and decodes space-bar make/break into flap/held
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_CYC = 100000,
   parameter logic [7:0] FLAP_CODE = DEFAULT_FLAP_CODE
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iPS2_CLK,
   input  logic       iPS2_DAT,
   output logic [7:0] oDATA,
   output logic       oVALID,
   output logic       oERR,
   output logic       oFLAP,
   output logic       oSPACE_HELD
);
   localparam int TW = $clog2(TIMEOUT_CYC);
   state_t state, state_n;
   logic fall_stb, data_s, good;
   logic [7:0] shift, shift_n, data_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic parity, parity_n, brk, brk_n, ext, ext_n;
   logic valid_n, err_n, flap_n, held_n;
   logic [TW-1:0] tcnt, tcnt_n;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk(iCLK), .rst(iRST), .ps2_clk(iPS2_CLK), .ps2_dat(iPS2_DAT),
      .fall_stb(fall_stb), .data_s(data_s)
   );

   assign good = data_s & (^shift ^ parity);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state <= IDLE;
         shift <= '0;
         bit_cnt <= '0;
         parity <= 1'b0;
         brk <= 1'b0;
         ext <= 1'b0;
         tcnt <= '0;
         oDATA <= '0;
         oVALID <= 1'b0;
         oERR <= 1'b0;
         oFLAP <= 1'b0;
         oSPACE_HELD <= 1'b0;
      end else begin
         state <= state_n;
         shift <= shift_n;
         bit_cnt <= bit_cnt_n;
         parity <= parity_n;
         brk <= brk_n;
         ext <= ext_n;
         tcnt <= tcnt_n;
         oDATA <= data_n;
         oVALID <= valid_n;
         oERR <= err_n;
         oFLAP <= flap_n;
         oSPACE_HELD <= held_n;
      end
   end

   always_comb begin
      state_n = state;
      shift_n = shift;
      bit_cnt_n = bit_cnt;
      parity_n = parity;
      tcnt_n = (state == IDLE) ? '0 : tcnt + TW'(1);
      data_n = oDATA;
      valid_n = 1'b0;
      err_n = 1'b0;
      flap_n = 1'b0;
      held_n = oSPACE_HELD;
      brk_n = brk;
      ext_n = ext;
      // an edge in the same cycle as expiry wins over the timeout
      if (fall_stb) begin
         tcnt_n = '0;
         case (state)
            IDLE: begin
               state_n = data_s ? IDLE : DATA;
               bit_cnt_n = '0;
            end
            DATA: begin
               shift_n = {data_s, shift[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               parity_n = data_s;
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               valid_n = good;
               err_n = ~good;
               data_n = good ? shift : oDATA;
            end
         endcase
      end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYC - 1)) begin
         err_n = 1'b1;
         state_n = IDLE;
         tcnt_n = '0;
      end
      if (valid_n) begin
         brk_n = (shift == BREAK_CODE) | (brk & (shift == EXT_CODE));
         ext_n = (shift == EXT_CODE) | (ext & (shift == BREAK_CODE));
         if (shift == FLAP_CODE && !ext) begin
            held_n = ~brk;
            flap_n = ~brk & ~oSPACE_HELD;
         end
      end
      if (err_n) begin
         brk_n = 1'b0;
         ext_n = 1'b0;
      end
   end
endmodule
